// File: rtl/fastica_frame_io.sv
// Frame streamer/capturer for the FastICA core: host-loaded input frame streamed one vector per cycle on go,
// returned vectors captured into a host-readable output frame; z and rd_data have one cycle of latency, and there is no z backpressure.
module fastica_frame_io #(
    parameter int NCH   = 4,
    parameter int W     = 26,
    parameter int DEPTH = 128,
    parameter int AW    = $clog2(DEPTH),
    parameter int CW    = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clk_fastica,
    input  logic                 rstn_fastica,
    input  logic                 wr_en,
    input  logic [CW-1:0]        wr_ch,
    input  logic [AW-1:0]        wr_addr,
    input  logic [W-1:0]         wr_data,
    input  logic                 go,
    output logic                 z_valid,
    output logic [NCH*W-1:0]     z,
    output logic [AW-1:0]        z_idx,
    input  logic                 y_valid,
    input  logic [NCH*W-1:0]     y,
    input  logic [CW-1:0]        rd_ch,
    input  logic [AW-1:0]        rd_addr,
    output logic [W-1:0]         rd_data,
    output logic                 busy,
    output logic                 done,
    output logic                 overflow
);

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_WAIT, S_DONE} state_t;

    localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);
    localparam logic [AW:0] LP_ONE   = (AW+1)'(1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [AW:0]       r_src_cnt;
    logic [AW:0]       r_cap_cnt;
    logic [AW:0]       w_cap_cnt_inc;
    logic [W-1:0]      r_in_mem  [NCH][DEPTH];
    logic [W-1:0]      r_out_mem [NCH][DEPTH];
    logic              r_z_valid;
    logic [NCH*W-1:0]  r_z;
    logic [NCH*W-1:0]  w_in_vec;
    logic [AW-1:0]     r_z_idx;
    logic [AW-1:0]     w_rd_idx;
    logic [W-1:0]      r_rd_data;
    logic              r_busy;
    logic              r_done;
    logic              r_overflow;
    logic              w_active;
    logic              w_cap_slot;
    logic              w_cap;
    logic              w_start;
    logic              w_stream_more;
    logic              w_wr_ok;
    logic              w_rd_ok;

    assign w_active      = (r_state == S_STREAM) || (r_state == S_WAIT);
    assign w_cap_slot    = w_active && (r_cap_cnt != LP_DEPTH);
    assign w_cap         = y_valid && w_cap_slot;
    assign w_cap_cnt_inc = r_cap_cnt + (AW+1)'(w_cap);
    assign w_start       = (r_state == S_IDLE) && go;
    assign w_stream_more = (r_state == S_STREAM) && (r_src_cnt != LP_DEPTH);
    assign w_rd_idx      = w_start ? '0 : r_src_cnt[AW-1:0];
    assign w_wr_ok       = (r_state == S_IDLE) && wr_en && (32'(wr_ch) < NCH);
    assign w_rd_ok       = 32'(rd_ch) < NCH;

    always_comb begin
        w_in_vec = '0;
        for (int c = 0; c < NCH; c++) begin
            w_in_vec[c*W +: W] = r_in_mem[c][w_rd_idx];
        end
    end

    // Completion looks at the post-capture count so a capture in the same cycle ends the frame immediately.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (go) w_state_nxt = S_STREAM;
            S_STREAM: if (r_src_cnt == LP_DEPTH)
                          w_state_nxt = (w_cap_cnt_inc == LP_DEPTH) ? S_DONE : S_WAIT;
            S_WAIT:   if (w_cap_cnt_inc == LP_DEPTH) w_state_nxt = S_DONE;
            S_DONE:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_fastica) begin
        if (!rstn_fastica) begin
            r_state    <= S_IDLE;
            r_src_cnt  <= '0;
            r_cap_cnt  <= '0;
            r_z_valid  <= 1'b0;
            r_z        <= '0;
            r_z_idx    <= '0;
            r_rd_data  <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_busy    <= (w_state_nxt == S_STREAM) || (w_state_nxt == S_WAIT);
            r_done    <= (w_state_nxt == S_DONE);
            r_z_valid <= w_start || w_stream_more;
            if (w_start || w_stream_more) begin
                r_z     <= w_in_vec;
                r_z_idx <= w_rd_idx;
            end
            if (w_start) begin
                r_src_cnt <= LP_ONE;
            end else if (w_stream_more) begin
                r_src_cnt <= r_src_cnt + LP_ONE;
            end
            r_cap_cnt <= w_start ? '0 : w_cap_cnt_inc;
            // A start clears the sticky flag, but a stray y_valid in that same cycle still counts.
            if (w_start) begin
                r_overflow <= y_valid;
            end else if (y_valid && !w_cap_slot) begin
                r_overflow <= 1'b1;
            end
            r_rd_data <= w_rd_ok ? r_out_mem[rd_ch][rd_addr] : '0;
        end
    end

    always_ff @(posedge clk_fastica) begin
        if (rstn_fastica && w_wr_ok) begin
            r_in_mem[wr_ch][wr_addr] <= wr_data;
        end
        if (rstn_fastica && w_cap) begin
            for (int c = 0; c < NCH; c++) begin
                r_out_mem[c][r_cap_cnt[AW-1:0]] <= y[c*W +: W];
            end
        end
    end

    assign z_valid  = r_z_valid;
    assign z        = r_z;
    assign z_idx    = r_z_idx;
    assign rd_data  = r_rd_data;
    assign busy     = r_busy;
    assign done     = r_done;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_fastica_frame_io.sv
// Bench for fastica_frame_io: a 4x26x128 and a 2x16x16 instance, driven from frame-level models of both memories.
module tb_fastica_frame_io;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rstn_a, wr_en_a, go_a, y_valid_a, z_valid_a, busy_a, done_a, ovf_a;
    logic [1:0]   wr_ch_a, rd_ch_a;
    logic [6:0]   wr_addr_a, rd_addr_a, z_idx_a;
    logic [25:0]  wr_data_a, rd_data_a;
    logic [103:0] z_a, y_a;

    logic         rstn_b, wr_en_b, go_b, y_valid_b, z_valid_b, busy_b, done_b, ovf_b;
    logic [0:0]   wr_ch_b, rd_ch_b;
    logic [3:0]   wr_addr_b, rd_addr_b, z_idx_b;
    logic [15:0]  wr_data_b, rd_data_b;
    logic [31:0]  z_b, y_b;

    fastica_frame_io #(.NCH(4), .W(26), .DEPTH(128)) u_dut_a (
        .clk_fastica(clk), .rstn_fastica(rstn_a),
        .wr_en(wr_en_a), .wr_ch(wr_ch_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
        .go(go_a), .z_valid(z_valid_a), .z(z_a), .z_idx(z_idx_a),
        .y_valid(y_valid_a), .y(y_a), .rd_ch(rd_ch_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
        .busy(busy_a), .done(done_a), .overflow(ovf_a)
    );

    fastica_frame_io #(.NCH(2), .W(16), .DEPTH(16)) u_dut_b (
        .clk_fastica(clk), .rstn_fastica(rstn_b),
        .wr_en(wr_en_b), .wr_ch(wr_ch_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
        .go(go_b), .z_valid(z_valid_b), .z(z_b), .z_idx(z_idx_b),
        .y_valid(y_valid_b), .y(y_b), .rd_ch(rd_ch_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
        .busy(busy_b), .done(done_b), .overflow(ovf_b)
    );

    int          n_chk = 0;
    int          n_err = 0;
    bit          sb;
    int          g_nch, g_dep;
    logic [25:0] g_msk;
    logic [25:0] m_in  [4][128];
    logic [25:0] m_out [4][128];
    logic [103:0] pq_d[$];
    int          pq_t[$];

    typedef struct {
        int          ch;
        int          addr;
        logic [25:0] exp;
    } rd_rec_t;
    rd_rec_t tbl[6];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic o_zv();   return sb ? z_valid_b : z_valid_a; endfunction
    function automatic logic o_busy(); return sb ? busy_b : busy_a;       endfunction
    function automatic logic o_done(); return sb ? done_b : done_a;       endfunction
    function automatic logic o_ovf();  return sb ? ovf_b : ovf_a;         endfunction
    function automatic int   o_zidx(); return sb ? int'(z_idx_b) : int'(z_idx_a); endfunction
    function automatic logic [25:0] o_rd(); return sb ? {10'b0, rd_data_b} : rd_data_a; endfunction
    function automatic logic [25:0] o_zch(input int c);
        if (sb) return {10'b0, z_b[c*16 +: 16]};
        return z_a[c*26 +: 26];
    endfunction

    task automatic drv_go(input logic v);
        if (sb) go_b = v; else go_a = v;
    endtask
    task automatic drv_rstn(input logic v);
        if (sb) rstn_b = v; else rstn_a = v;
    endtask
    task automatic drv_y(input logic v, input logic [103:0] d);
        if (sb) begin y_valid_b = v; y_b = {d[26 +: 16], d[0 +: 16]}; end
        else    begin y_valid_a = v; y_a = d; end
    endtask
    task automatic drv_wr(input logic en, input int c, input int a, input logic [25:0] d);
        if (sb) begin wr_en_b = en; wr_ch_b = 1'(c); wr_addr_b = 4'(a); wr_data_b = d[15:0]; end
        else    begin wr_en_a = en; wr_ch_a = 2'(c); wr_addr_a = 7'(a); wr_data_a = d; end
    endtask
    task automatic drv_rd(input int c, input int a);
        if (sb) begin rd_ch_b = 1'(c); rd_addr_b = 4'(a); end
        else    begin rd_ch_a = 2'(c); rd_addr_a = 7'(a); end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_z_valid"}, o_zv(), 0);
        chk({tag, "_z_idx"}, o_zidx(), 0);
        for (int c = 0; c < g_nch; c++) chk({tag, "_z"}, o_zch(c), 0);
        chk({tag, "_rd_data"}, o_rd(), 0);
        chk({tag, "_busy"}, o_busy(), 0);
        chk({tag, "_done"}, o_done(), 0);
        chk({tag, "_overflow"}, o_ovf(), 0);
    endtask

    // kind 0: c*256+i pattern, 1: random, 2: random with fixed sign-boundary words
    task automatic load_frame(input int kind);
        logic [25:0] v;
        for (int c = 0; c < g_nch; c++) begin
            for (int i = 0; i < g_dep; i++) begin
                if (kind == 0) v = 26'(c*256 + i);
                else           v = 26'($urandom) & g_msk;
                if (kind == 2 && c == 0 && i == 0) v = 26'h8000;
                if (kind == 2 && c == 1 && i == 1) v = 26'hFFFF;
                if (kind == 2 && c == 1 && i == 2) v = 26'h7FFF;
                m_in[c][i] = v;
                @(negedge clk);
                drv_wr(1'b1, c, i, v);
            end
        end
        @(negedge clk);
        drv_wr(1'b0, 0, 0, '0);
    endtask

    // The "core": each streamed vector becomes eligible dly cycles later and is returned
    // when the gate allows (0 always, 1 even cycles, 2 random, with random payload).
    task automatic run_frame(input int dly, input int gmode, input int inj_cyc,
                             input int abort_cyc, output int done_cyc);
        int nv, ncap, last_cap, first_v, last_v, ndone, busy_bad, ovf1, quiet_bad;
        bit aborted, gate;
        logic [103:0] v, yd;
        nv = 0; ncap = 0; last_cap = -1; first_v = -1; last_v = -1; ndone = 0;
        busy_bad = 0; ovf1 = -1; quiet_bad = 0; aborted = 0; done_cyc = -1;
        pq_d.delete(); pq_t.delete();
        @(negedge clk);
        drv_go(1'b1);
        for (int cyc = 1; cyc <= 4*g_dep + 40; cyc++) begin
            @(negedge clk);
            drv_go(1'b0);
            drv_wr(1'b0, 0, 0, '0);
            drv_y(1'b0, '0);
            if (cyc == 1) ovf1 = int'(o_ovf());
            if (o_zv()) begin
                if (first_v < 0) first_v = cyc;
                last_v = cyc;
                chk("z_idx", o_zidx(), nv);
                v = '0;
                for (int c = 0; c < g_nch; c++) begin
                    if (nv < g_dep) chk("z_data", o_zch(c), m_in[c][nv]);
                    v[c*26 +: 26] = o_zch(c);
                end
                pq_d.push_back(v);
                pq_t.push_back(cyc + dly);
                nv++;
            end
            if (o_busy() !== !o_done()) busy_bad++;
            if (o_done()) begin
                ndone++;
                done_cyc = cyc;
                chk("ovf_at_done", o_ovf(), 0);
                chk("z_idx_hold", o_zidx(), g_dep - 1);
                chk("z_hold", o_zch(0), m_in[0][g_dep-1]);
                break;
            end
            if (cyc == abort_cyc) begin
                drv_rstn(1'b0);
                aborted = 1;
                break;
            end
            if (cyc == inj_cyc) begin
                drv_go(1'b1);
                drv_wr(1'b1, 0, 0, ~m_in[0][0] & g_msk);
            end
            gate = (gmode == 0) || (gmode == 1 && cyc % 2 == 0) ||
                   (gmode == 2 && $urandom_range(0, 2) != 0);
            if (gate && pq_d.size() > 0 && pq_t[0] <= cyc) begin
                yd = pq_d.pop_front();
                void'(pq_t.pop_front());
                if (gmode == 2)
                    for (int c = 0; c < g_nch; c++) yd[c*26 +: 26] = 26'($urandom) & g_msk;
                if (ncap < g_dep)
                    for (int c = 0; c < g_nch; c++) m_out[c][ncap] = yd[c*26 +: 26];
                ncap++;
                last_cap = cyc;
                drv_y(1'b1, yd);
            end
        end
        if (aborted) begin
            @(negedge clk);
            drv_rstn(1'b1);
            chk_zero_outputs("abort");
            repeat (4) begin
                @(negedge clk);
                if (o_done() || o_busy() || o_zv()) quiet_bad++;
            end
            chk("abort_quiet", quiet_bad, 0);
        end else begin
            chk("zv_first", first_v, 1);
            chk("zv_count", nv, g_dep);
            chk("zv_last", last_v, g_dep);
            chk("cap_count", ncap, g_dep);
            chk("done_cycle", done_cyc, last_cap + 1);
            chk("busy_profile", busy_bad, 0);
            chk("ovf_cleared", ovf1, 0);
            @(negedge clk);
            chk("done_one_cycle", o_done(), 0);
            chk("busy_after", o_busy(), 0);
        end
    endtask

    task automatic readback_all();
        for (int k = 0; k <= g_nch*g_dep; k++) begin
            @(negedge clk);
            if (k > 0) chk("readback", o_rd(), m_out[(k-1)/g_dep][(k-1)%g_dep]);
            if (k < g_nch*g_dep) drv_rd(k / g_dep, k % g_dep);
        end
    endtask

    initial begin
        int dc;
        tbl[0] = '{2,   5, 26'h205};
        tbl[1] = '{0,   0, 26'h000};
        tbl[2] = '{3, 127, 26'h37F};
        tbl[3] = '{1,  64, 26'h140};
        tbl[4] = '{0, 127, 26'h07F};
        tbl[5] = '{3,   0, 26'h300};

        rstn_a = 0; wr_en_a = 0; go_a = 0; y_valid_a = 0; wr_ch_a = 0; rd_ch_a = 0;
        wr_addr_a = 0; rd_addr_a = 0; wr_data_a = 0; y_a = '0;
        rstn_b = 0; wr_en_b = 0; go_b = 0; y_valid_b = 0; wr_ch_b = 0; rd_ch_b = 0;
        wr_addr_b = 0; rd_addr_b = 0; wr_data_b = 0; y_b = '0;
        repeat (3) @(negedge clk);

        sb = 1; g_nch = 2; g_dep = 16; g_msk = 26'hFFFF;
        chk_zero_outputs("reset_b");
        sb = 0; g_nch = 4; g_dep = 128; g_msk = 26'h3FF_FFFF;
        chk_zero_outputs("reset_a");
        rstn_a = 1; rstn_b = 1;

        load_frame(0);
        run_frame(3, 0, -1, -1, dc);
        chk("f1_done_cycle", dc, 132);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            drv_rd(tbl[i].ch, tbl[i].addr);
            @(negedge clk);
            chk("tbl_readback", o_rd(), tbl[i].exp);
        end

        run_frame(0, 1, -1, -1, dc);
        readback_all();

        @(negedge clk);
        drv_y(1'b1, {4{26'h155_5555}});
        @(negedge clk);
        drv_y(1'b0, '0);
        drv_rd(0, 0);
        chk("ovf_set", o_ovf(), 1);
        @(negedge clk);
        chk("ovf_sticky", o_ovf(), 1);
        chk("ovf_no_write", o_rd(), m_out[0][0]);

        run_frame(1, 0, 50, -1, dc);
        run_frame(2, 0, -1, 60, dc);
        run_frame(3, 0, -1, -1, dc);
        readback_all();

        load_frame(1);
        run_frame($urandom_range(0, 5), 2, -1, -1, dc);
        readback_all();

        sb = 1; g_nch = 2; g_dep = 16; g_msk = 26'hFFFF;
        load_frame(2);
        run_frame(0, 0, -1, -1, dc);
        chk("b_done_cycle", dc, 17);
        readback_all();
        @(negedge clk);
        drv_rd(0, 0);
        @(negedge clk);
        chk("b_neg_word", o_rd(), 26'h8000);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/fastica_frame_io.md
Name: fastica_frame_io

Overview:
Parametrised frame streamer/capturer for the FastICA core on the clk_fastica domain. It holds one frame of whitened input samples (NCH channels x DEPTH samples, W-bit signed) loaded by a host port. On go it streams the frame to the ICA core one sample-vector per cycle. It captures the returned separated vectors into an output frame that the host reads back. It replaces fixed 4-channel/128-sample stimulus-and-capture handling with a synthesizable, handshaked block.

Parameters:
NCH, 4, number of channels (>=1)
W, 26, sample width, two's complement
DEPTH, 128, samples per frame (power of two, >=2)
AW, $clog2(DEPTH), sample address width
CW, (NCH>1 ? $clog2(NCH) : 1), channel index width

Ports:
clk_fastica  in  1  block clock, all logic rising-edge
rstn_fastica  in  1  synchronous active-low reset
wr_en  in  1  host write strobe into input frame
wr_ch  in  CW  channel index for write
wr_addr  in  AW  sample index for write
wr_data  in  W  sample value
go  in  1  start request, sampled each cycle
z_valid  out  1  z/z_idx carry a valid sample vector
z  out  NCH*W  sample vector, channel 0 in bits [W-1:0]
z_idx  out  AW  sample index of current z
y_valid  in  1  core result valid
y  in  NCH*W  result vector, same packing as z
rd_ch  in  CW  host read channel
rd_addr  in  AW  host read sample index
rd_data  out  W  output-frame word, 1-cycle read latency
busy  out  1  high in STREAM or WAIT
done  out  1  one-cycle pulse at frame completion
overflow  out  1  sticky: y_valid arrived with no slot available

Behaviour:
- Reset (rstn_fastica=0 at a clock edge): state IDLE; z_valid, z, z_idx, rd_data, busy, done, overflow = 0; both counters = 0. Frame memories are not cleared. Reset mid-operation aborts immediately; no done pulse.
- States: IDLE, STREAM, WAIT, DONE.
- IDLE:
  - wr_en writes wr_data to in_mem[wr_ch][wr_addr]. wr_ch >= NCH is ignored.
  - go=1 -> STREAM; src_cnt=0, cap_cnt=0, overflow cleared.
- STREAM:
  - Input memory read is registered. z_valid is high for exactly DEPTH consecutive cycles, starting the cycle after go is sampled.
  - z_idx counts 0..DEPTH-1; z holds in_mem[*][z_idx].
  - After the vector with z_idx=DEPTH-1: go to WAIT, or go to DONE if capture is already complete.
  - z/z_idx hold their last values when z_valid=0.
- Capture (STREAM or WAIT):
  - y_valid=1 with cap_cnt<DEPTH writes y into out_mem[*][cap_cnt]; cap_cnt increments.
  - Gaps in y_valid are allowed.
  - Capture may overlap streaming, for pipelined cores.
- WAIT: remain until cap_cnt reaches DEPTH, then go to DONE. There is no timeout; reset is the only exit.
- DONE: done=1 for one cycle, busy=0, then IDLE.
- busy: registered; high in STREAM and WAIT.
- Ignored inputs:
  - go while not IDLE.
  - wr_en while busy.
  - y_valid in IDLE/DONE, or with cap_cnt=DEPTH; each sets overflow, data discarded.
- Read port: rd_data = out_mem[rd_ch][rd_addr], registered, legal in any state. It returns stored content; a word being written the same cycle returns its old value. rd_ch >= NCH returns 0.
- Arithmetic: none on data; samples pass bit-exact. Counters are AW+1 bits wide so DEPTH is representable; no wrap inside a frame.

Test Plan:
- Load in_mem[c][i] = c*256 + i (NCH=4, DEPTH=128); go at cycle 0; loopback y = z delayed 3 cycles -> z_valid cycles 1..128, z_idx 0..127; y captured cycles 4..131; done pulse cycle 132; readback out_mem[2][5] = 0x205.
- Same frame, y_valid asserted every other cycle -> all 128 vectors captured in order; WAIT entered after cycle 128; done one cycle after the 128th capture; overflow=0.
- After done, one extra y_valid -> overflow=1, out_mem unchanged; next go clears overflow.
- go pulsed again at cycle 50 of streaming, and wr_en writing in_mem[0][0] mid-frame -> no restart, z_idx continuous, in_mem[0][0] keeps its old value.
- rstn_fastica=0 at cycle 60 of streaming -> next cycle all outputs 0, state IDLE, no done; a new go streams from z_idx 0 with the preloaded data intact.
- Re-elaborate with NCH=2, W=16, DEPTH=16, loopback delay 0 -> 16 vectors streamed, done cycle 17, data bit-exact including negative value 0x8000.
